// File: rtl/huff_pkg.sv
// Shared definitions for the canonical-Huffman decoder slice.
// Holds symbol/code widths, the FSM state encoding and the table address map.
// The interface, huff_table and huff_decode all import this package.
package huff_pkg;

    localparam int SYM_W   = 3;   // residual symbol width (0..6 => -3..+3)
    localparam int NUM_SYM = 7;   // number of distinct symbols
    localparam int MAX_LEN = 6;   // longest codeword, in bits
    localparam int CODE_W  = 6;   // width of the code / first accumulators

    // Table address map: counts live at CNT_BASE + (len-1),
    // symbols in canonical order at SYM_BASE + index.
    localparam logic [3:0] CNT_BASE = 4'd0;
    localparam logic [3:0] SYM_BASE = 4'd8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DECODE = 2'd1,
        DONE   = 2'd2,
        ERR    = 2'd3
    } state_e;

endpackage

// File: rtl/huff_decode_if.sv
// Bus interface for huff_decode.
// Bundles frame control, table load port, serial bit input, symbol output,
// status flags and the FSM state (for observation). The slave modport is the
// decoder view; the master modport is the view of whatever drives it.
// Handshake: a bit is transferred on a rising Clk edge when Bit_valid and
// Bit_ready are both 1; Bit_in must be stable while Bit_valid is 1, and a bit
// offered while Bit_ready is 0 is left unconsumed. Sym_valid is a one-cycle
// pulse with no back-pressure.
// When HUFF_DECODE_HIST_EN is defined, Hist_sel / Hist_count are added.
interface huff_decode_if;
    import huff_pkg::*;

    logic               Start;
    logic               Tbl_wr_en;
    logic [3:0]         Tbl_addr;
    logic [SYM_W-1:0]   Tbl_data;
    logic               Bit_in;
    logic               Bit_valid;
    logic               Bit_ready;
    logic [SYM_W-1:0]   Sym_out;
    logic               Sym_valid;
    logic               Done;
    logic               Err;
    state_e             state;
`ifdef HUFF_DECODE_HIST_EN
    logic [SYM_W-1:0]   Hist_sel;
    logic [7:0]         Hist_count;
`endif

    modport slave (
        input  Start, Tbl_wr_en, Tbl_addr, Tbl_data, Bit_in, Bit_valid,
`ifdef HUFF_DECODE_HIST_EN
        input  Hist_sel,
        output Hist_count,
`endif
        output Bit_ready, Sym_out, Sym_valid, Done, Err, state
    );

    modport master (
        output Start, Tbl_wr_en, Tbl_addr, Tbl_data, Bit_in, Bit_valid,
`ifdef HUFF_DECODE_HIST_EN
        output Hist_sel,
        input  Hist_count,
`endif
        input  Bit_ready, Sym_out, Sym_valid, Done, Err, state
    );

endinterface

// File: rtl/huff_table.sv
// Code table register file for huff_decode.
// Holds cnt[1..MAX_LEN] (number of codes of each length) and sym[0..NUM_SYM-1]
// (symbols in canonical order). One synchronous write port, two
// combinational read ports. Out-of-map addresses are dropped.
// Ports:
//   Clk, Reset      clock, asynchronous active-low reset (clears all entries)
//   wr_en/addr/data write port, addresses follow the huff_pkg map
//   rd_len/cnt_out  cnt[rd_len], 0 for lengths outside 1..MAX_LEN
//   rd_idx/sym_out  sym[rd_idx], 0 for index NUM_SYM
module huff_table
    import huff_pkg::*;
(
    input  logic             Clk,
    input  logic             Reset,
    input  logic             wr_en,
    input  logic [3:0]       wr_addr,
    input  logic [SYM_W-1:0] wr_data,
    input  logic [2:0]       rd_len,
    output logic [2:0]       cnt_out,
    input  logic [2:0]       rd_idx,
    output logic [SYM_W-1:0] sym_out
);

    logic [2:0]       cnt_q [MAX_LEN];
    logic [SYM_W-1:0] sym_q [NUM_SYM];

    // Offsets relative to each region; wrap-around keeps the range test a
    // single unsigned compare.
    logic [3:0] cnt_off;
    logic [3:0] sym_off;

    assign cnt_off = wr_addr - CNT_BASE;
    assign sym_off = wr_addr - SYM_BASE;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < MAX_LEN; i++) cnt_q[i] <= '0;
            for (int i = 0; i < NUM_SYM; i++) sym_q[i] <= '0;
        end else if (wr_en) begin
            if (cnt_off < 4'(MAX_LEN))
                cnt_q[cnt_off[2:0]] <= wr_data;
            else if (sym_off < 4'(NUM_SYM))
                sym_q[sym_off[2:0]] <= wr_data;
        end
    end

    always_comb begin
        cnt_out = '0;
        if (rd_len != 3'd0 && rd_len <= 3'(MAX_LEN))
            cnt_out = cnt_q[rd_len - 3'd1];
    end

    always_comb begin
        sym_out = '0;
        if (rd_idx < 3'(NUM_SYM))
            sym_out = sym_q[rd_idx];
    end

endmodule

// File: rtl/huff_decode.sv
// Canonical-Huffman bitstream decoder (receive side of the MUA path).
// Consumes one coded bit per cycle (MSB-first per codeword) and emits 3-bit
// residual symbols; a frame is FRAME_LEN symbols, after which Done is set.
// A codeword that has not matched by MAX_LEN bits puts the block into ERR.
// Ports:
//   Clk    clock
//   Reset  asynchronous active-low reset (also clears the code table)
//   bus    huff_decode_if.slave: Start, table write port, Bit_in/Bit_valid/
//          Bit_ready, Sym_out/Sym_valid, Done, Err, state
// Build option: HUFF_DECODE_HIST_EN adds per-symbol 8-bit occurrence
// counters read through Hist_sel / Hist_count.
module huff_decode
    import huff_pkg::*;
#(
    parameter int FRAME_LEN = 255
) (
    input  logic           Clk,
    input  logic           Reset,
    huff_decode_if.slave   bus
);

    state_e              state_q;
    logic [CODE_W-1:0]   code_q;
    logic [CODE_W-1:0]   first_q;
    logic [2:0]          len_q;
    logic [2:0]          index_q;
    logic [7:0]          sym_cnt_q;
    logic                bit_ready_q;
    logic [SYM_W-1:0]    sym_out_q;
    logic                sym_valid_q;
    logic                done_q;
    logic                err_q;

    logic                bit_acc;
    logic                tbl_we;
    logic [CODE_W-1:0]   c;
    logic [2:0]          l;
    logic [2:0]          n;
    logic [CODE_W-1:0]   off;
    logic                hit;
    logic [2:0]          sym_idx;
    logic [SYM_W-1:0]    tbl_sym;
    logic [CODE_W-1:0]   first_sum;
    logic [7:0]          sym_cnt_nxt;

    // Bit_ready is registered and only ever 1 in DECODE.
    assign bit_acc     = bus.Bit_valid & bit_ready_q;
    assign tbl_we      = bus.Tbl_wr_en & (state_q != DECODE);

    assign c           = {code_q[CODE_W-2:0], bus.Bit_in};
    assign l           = len_q + 3'd1;
    assign off         = c - first_q;
    assign hit         = off < {3'b000, n};
    assign sym_idx     = index_q + off[2:0];   // deliberately truncated
    assign first_sum   = first_q + {3'b000, n};
    assign sym_cnt_nxt = sym_cnt_q + 8'd1;

    huff_table u_table (
        .Clk     (Clk),
        .Reset   (Reset),
        .wr_en   (tbl_we),
        .wr_addr (bus.Tbl_addr),
        .wr_data (bus.Tbl_data),
        .rd_len  (l),
        .cnt_out (n),
        .rd_idx  (sym_idx),
        .sym_out (tbl_sym)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q     <= IDLE;
            code_q      <= '0;
            first_q     <= '0;
            len_q       <= '0;
            index_q     <= '0;
            sym_cnt_q   <= '0;
            bit_ready_q <= 1'b0;
            sym_out_q   <= '0;
            sym_valid_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            case (state_q)
                IDLE, DONE, ERR: begin
                    if (bus.Start) begin
                        state_q     <= DECODE;
                        code_q      <= '0;
                        first_q     <= '0;
                        len_q       <= '0;
                        index_q     <= '0;
                        sym_cnt_q   <= '0;
                        bit_ready_q <= 1'b1;
                        done_q      <= 1'b0;
                        err_q       <= 1'b0;
                    end
                end
                DECODE: begin
                    if (bit_acc) begin
                        if (hit) begin
                            sym_out_q   <= tbl_sym;
                            sym_valid_q <= 1'b1;
                            code_q      <= '0;
                            first_q     <= '0;
                            len_q       <= '0;
                            index_q     <= '0;
                            sym_cnt_q   <= sym_cnt_nxt;
                            // Final symbol: Done and the ready drop land in
                            // the same cycle as its Sym_valid pulse.
                            if (sym_cnt_nxt == 8'(FRAME_LEN)) begin
                                state_q     <= DONE;
                                done_q      <= 1'b1;
                                bit_ready_q <= 1'b0;
                            end
                        end else if (l == 3'(MAX_LEN)) begin
                            state_q     <= ERR;
                            err_q       <= 1'b1;
                            bit_ready_q <= 1'b0;
                        end else begin
                            index_q <= index_q + n;
                            first_q <= {first_sum[CODE_W-2:0], 1'b0};
                            code_q  <= c;
                            len_q   <= l;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.Bit_ready = bit_ready_q;
    assign bus.Sym_out   = sym_out_q;
    assign bus.Sym_valid = sym_valid_q;
    assign bus.Done      = done_q;
    assign bus.Err       = err_q;
    assign bus.state     = state_q;

`ifdef HUFF_DECODE_HIST_EN
    logic [7:0] hist_q [NUM_SYM];

    // Counted at the decode edge, so each count tracks its Sym_valid pulse.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < NUM_SYM; i++) hist_q[i] <= '0;
        end else if (state_q != DECODE && bus.Start) begin
            for (int i = 0; i < NUM_SYM; i++) hist_q[i] <= '0;
        end else if (state_q == DECODE && bit_acc && hit &&
                     tbl_sym < 3'(NUM_SYM)) begin
            hist_q[tbl_sym] <= hist_q[tbl_sym] + 8'd1;
        end
    end

    always_comb begin
        bus.Hist_count = '0;
        if (bus.Hist_sel < 3'(NUM_SYM))
            bus.Hist_count = hist_q[bus.Hist_sel];
    end
`endif

endmodule

// File: tb/tb_huff_decode.sv
// Directed testbench for huff_decode.
// Two decoders share one stimulus stream: u_main (FRAME_LEN=255) and
// u_frame (FRAME_LEN=4, used for the frame-end scenario).
// With HUFF_DECODE_HIST_EN defined the histogram scenario is also run.
module tb_huff_decode;
    import huff_pkg::*;

    logic Clk;
    logic Reset;
    int   n_checks;
    int   n_fail;

    huff_decode_if m_if ();
    huff_decode_if f_if ();

    assign f_if.Start     = m_if.Start;
    assign f_if.Tbl_wr_en = m_if.Tbl_wr_en;
    assign f_if.Tbl_addr  = m_if.Tbl_addr;
    assign f_if.Tbl_data  = m_if.Tbl_data;
    assign f_if.Bit_in    = m_if.Bit_in;
    assign f_if.Bit_valid = m_if.Bit_valid;
`ifdef HUFF_DECODE_HIST_EN
    assign f_if.Hist_sel  = m_if.Hist_sel;
`endif

    huff_decode #(.FRAME_LEN(255)) u_main (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (m_if.slave)
    );

    huff_decode #(.FRAME_LEN(4)) u_frame (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (f_if.slave)
    );

    // Full table: counts L1..L6 = 1,1,1,1,1,2 ; order 3,2,4,1,5,0,6
    localparam logic [17:0] FULL_CNTS = {3'd2, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1};
    localparam logic [20:0] FULL_SYMS = {3'd6, 3'd0, 3'd5, 3'd1, 3'd4, 3'd2, 3'd3};
    // Short table: L1=1, L2=1, rest 0
    localparam logic [17:0] SHORT_CNTS = {3'd0, 3'd0, 3'd0, 3'd0, 3'd1, 3'd1};

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic do_reset();
        Reset = 1'b0;
        m_if.Start = 1'b0;
        m_if.Tbl_wr_en = 1'b0;
        m_if.Tbl_addr = '0;
        m_if.Tbl_data = '0;
        m_if.Bit_in = 1'b0;
        m_if.Bit_valid = 1'b0;
`ifdef HUFF_DECODE_HIST_EN
        m_if.Hist_sel = '0;
`endif
        repeat (2) @(posedge Clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge Clk);
        Reset = 1'b1;
    endtask

    // ---------------- drivers ----------------
    task automatic wr_tbl(input logic [3:0] addr, input logic [2:0] data);
        @(negedge Clk);
        m_if.Tbl_wr_en = 1'b1;
        m_if.Tbl_addr  = addr;
        m_if.Tbl_data  = data;
        @(posedge Clk);
        #1;
        m_if.Tbl_wr_en = 1'b0;
    endtask

    task automatic load_table(input logic [17:0] cnts, input logic [20:0] syms);
        for (int i = 0; i < 6; i++) wr_tbl(4'(i), cnts[3*i +: 3]);
        for (int i = 0; i < 7; i++) wr_tbl(4'(8 + i), syms[3*i +: 3]);
    endtask

    task automatic pulse_start();
        @(negedge Clk);
        m_if.Start = 1'b1;
        @(posedge Clk);
        #1;
        m_if.Start = 1'b0;
    endtask

    task automatic send_bit(input logic b);
        @(negedge Clk);
        m_if.Bit_in    = b;
        m_if.Bit_valid = 1'b1;
        @(posedge Clk);
        #1;
        m_if.Bit_valid = 1'b0;
    endtask

    task automatic idle_cycle();
        @(negedge Clk);
        m_if.Bit_valid = 1'b0;
        @(posedge Clk);
        #1;
    endtask

    // Sends one codeword to u_main, checking no pulse mid-codeword and the
    // expected symbol one cycle after the last bit.
    task automatic send_code(input string name, input int len,
                             input logic [5:0] code, input logic [2:0] exp_sym);
        for (int i = len - 1; i >= 0; i--) begin
            send_bit(code[i]);
            if (i > 0) begin
                n_checks++;
                if (m_if.Sym_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL %s mid_valid: got %b expected 0", name, m_if.Sym_valid);
                end
            end else begin
                n_checks++;
                if (m_if.Sym_valid !== 1'b1 || m_if.Sym_out !== exp_sym) begin
                    n_fail++;
                    $display("FAIL %s symbol: got valid=%b sym=%0d expected valid=1 sym=%0d",
                             name, m_if.Sym_valid, m_if.Sym_out, exp_sym);
                end
            end
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        n_checks++;
        if (m_if.Bit_ready !== 1'b0 || m_if.Sym_out !== 3'd0 || m_if.Sym_valid !== 1'b0 ||
            m_if.Done !== 1'b0 || m_if.Err !== 1'b0 || m_if.state !== IDLE) begin
            n_fail++;
            $display("FAIL reset_outputs: got rdy=%b sym=%0d sv=%b done=%b err=%b st=%0d expected all 0",
                     m_if.Bit_ready, m_if.Sym_out, m_if.Sym_valid, m_if.Done, m_if.Err, m_if.state);
        end
        release_reset();
        // A bit offered in IDLE is not taken.
        send_bit(1'b0);
        n_checks++;
        if (m_if.Sym_valid !== 1'b0 || m_if.Bit_ready !== 1'b0 || m_if.state !== IDLE) begin
            n_fail++;
            $display("FAIL idle_bit_ignored: got sv=%b rdy=%b st=%0d expected 0 0 IDLE",
                     m_if.Sym_valid, m_if.Bit_ready, m_if.state);
        end
    endtask

    task automatic test_all_symbols();
        logic [5:0] codes [7];
        int         lens  [7];
        logic [2:0] exps  [7];
        codes = '{6'd0, 6'd2, 6'd6, 6'd14, 6'd30, 6'd62, 6'd63};
        lens  = '{1, 2, 3, 4, 5, 6, 6};
        exps  = '{3'd3, 3'd2, 3'd4, 3'd1, 3'd5, 3'd0, 3'd6};
        load_table(FULL_CNTS, FULL_SYMS);
        pulse_start();
        n_checks++;
        if (m_if.Bit_ready !== 1'b1 || m_if.state !== DECODE) begin
            n_fail++;
            $display("FAIL start_decode: got rdy=%b st=%0d expected 1 DECODE",
                     m_if.Bit_ready, m_if.state);
        end
        for (int k = 0; k < 7; k++) send_code("all_symbols", lens[k], codes[k], exps[k]);
        idle_cycle();
        n_checks++;
        if (m_if.Sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL sym_valid_pulse: got %b expected 0", m_if.Sym_valid);
        end
    endtask

    task automatic test_frame_end();
        logic       bits   [5];
        logic       exp_sv [5];
        logic [2:0] exp_s  [5];
        bits   = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        exp_sv = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        exp_s  = '{3'd3, 3'd3, 3'd0, 3'd2, 3'd3};
        pulse_start();
        n_checks++;
        if (f_if.Done !== 1'b0 || f_if.Bit_ready !== 1'b1 || m_if.state !== DECODE) begin
            n_fail++;
            $display("FAIL frame_restart: got f_done=%b f_rdy=%b m_st=%0d expected 0 1 DECODE",
                     f_if.Done, f_if.Bit_ready, m_if.state);
        end
        for (int k = 0; k < 5; k++) begin
            send_bit(bits[k]);
            n_checks++;
            if (f_if.Sym_valid !== exp_sv[k] || (exp_sv[k] && f_if.Sym_out !== exp_s[k])) begin
                n_fail++;
                $display("FAIL frame_sym%0d: got sv=%b sym=%0d expected sv=%b sym=%0d",
                         k, f_if.Sym_valid, f_if.Sym_out, exp_sv[k], exp_s[k]);
            end
            n_checks++;
            if (f_if.Done !== (k == 4) || f_if.Bit_ready !== (k != 4)) begin
                n_fail++;
                $display("FAIL frame_done%0d: got done=%b rdy=%b expected done=%b rdy=%b",
                         k, f_if.Done, f_if.Bit_ready, k == 4, k != 4);
            end
        end
        // Extra bit: frame decoder must not consume it (u_main decodes it as 3).
        send_bit(1'b0);
        n_checks++;
        if (f_if.Sym_valid !== 1'b0 || f_if.Done !== 1'b1 || f_if.state !== DONE) begin
            n_fail++;
            $display("FAIL frame_extra_bit: got sv=%b done=%b st=%0d expected 0 1 DONE",
                     f_if.Sym_valid, f_if.Done, f_if.state);
        end
        n_checks++;
        if (m_if.Sym_valid !== 1'b1 || m_if.Sym_out !== 3'd3) begin
            n_fail++;
            $display("FAIL main_extra_sym: got sv=%b sym=%0d expected 1 3",
                     m_if.Sym_valid, m_if.Sym_out);
        end
    endtask

    task automatic test_bit_valid_toggle();
        send_bit(1'b1);
        idle_cycle();
        n_checks++;
        if (m_if.Sym_valid !== 1'b0 || m_if.Bit_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL toggle_gap1: got sv=%b rdy=%b expected 0 1", m_if.Sym_valid, m_if.Bit_ready);
        end
        send_bit(1'b1);
        idle_cycle();
        n_checks++;
        if (m_if.Sym_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL toggle_gap2: got sv=%b expected 0", m_if.Sym_valid);
        end
        send_bit(1'b0);
        n_checks++;
        if (m_if.Sym_valid !== 1'b1 || m_if.Sym_out !== 3'd4) begin
            n_fail++;
            $display("FAIL toggle_symbol: got sv=%b sym=%0d expected 1 4", m_if.Sym_valid, m_if.Sym_out);
        end
    endtask

    task automatic test_reset_mid_codeword();
        send_bit(1'b1);
        send_bit(1'b1);
        @(negedge Clk);
        #2;
        Reset = 1'b0;
        #1;
        n_checks++;
        if (m_if.Bit_ready !== 1'b0 || m_if.Sym_out !== 3'd0 || m_if.Done !== 1'b0 ||
            m_if.Err !== 1'b0 || m_if.state !== IDLE || f_if.Done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got rdy=%b sym=%0d done=%b err=%b st=%0d f_done=%b expected 0 0 0 0 IDLE 0",
                     m_if.Bit_ready, m_if.Sym_out, m_if.Done, m_if.Err, m_if.state, f_if.Done);
        end
        release_reset();
        // Cleared table: all counts 0, so six bits never match.
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            send_bit(1'b0);
            n_checks++;
            if (m_if.Sym_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL cleared_table_bit%0d: got sv=%b expected 0", k, m_if.Sym_valid);
            end
        end
        n_checks++;
        if (m_if.Err !== 1'b1 || m_if.state !== ERR) begin
            n_fail++;
            $display("FAIL cleared_table_err: got err=%b st=%0d expected 1 ERR", m_if.Err, m_if.state);
        end
        load_table(FULL_CNTS, FULL_SYMS);
        pulse_start();
        send_code("after_reset", 2, 6'd2, 3'd2);
    endtask

    task automatic test_error();
        do_reset();
        release_reset();
        load_table(SHORT_CNTS, FULL_SYMS);
        pulse_start();
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (m_if.Bit_ready !== 1'b1 || m_if.Err !== 1'b0) begin
                n_fail++;
                $display("FAIL err_pre%0d: got rdy=%b err=%b expected 1 0", k, m_if.Bit_ready, m_if.Err);
            end
            send_bit(1'b1);
            n_checks++;
            if (m_if.Sym_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL err_bit%0d: got sv=%b expected 0", k, m_if.Sym_valid);
            end
        end
        n_checks++;
        if (m_if.Err !== 1'b1 || m_if.state !== ERR || m_if.Bit_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL err_state: got err=%b st=%0d rdy=%b expected 1 ERR 0",
                     m_if.Err, m_if.state, m_if.Bit_ready);
        end
        send_bit(1'b0);
        n_checks++;
        if (m_if.Err !== 1'b1 || m_if.Sym_valid !== 1'b0 || m_if.state !== ERR) begin
            n_fail++;
            $display("FAIL err_sticky: got err=%b sv=%b st=%0d expected 1 0 ERR",
                     m_if.Err, m_if.Sym_valid, m_if.state);
        end
        pulse_start();
        n_checks++;
        if (m_if.Err !== 1'b0 || m_if.state !== DECODE) begin
            n_fail++;
            $display("FAIL err_restart: got err=%b st=%0d expected 0 DECODE", m_if.Err, m_if.state);
        end
        send_code("err_resume_0", 1, 6'd0, 3'd3);
        send_code("err_resume_10", 2, 6'd2, 3'd2);
    endtask

`ifdef HUFF_DECODE_HIST_EN
    task automatic test_hist();
        logic [2:0] sels [4];
        logic [7:0] exps [4];
        sels = '{3'd3, 3'd2, 3'd6, 3'd0};
        exps = '{8'd2, 8'd1, 8'd1, 8'd0};
        do_reset();
        release_reset();
        load_table(FULL_CNTS, FULL_SYMS);
        pulse_start();
        send_code("hist_a", 1, 6'd0, 3'd3);
        send_code("hist_b", 1, 6'd0, 3'd3);
        send_code("hist_c", 2, 6'd2, 3'd2);
        send_code("hist_d", 6, 6'd63, 3'd6);
        idle_cycle();
        for (int k = 0; k < 4; k++) begin
            m_if.Hist_sel = sels[k];
            #1;
            n_checks++;
            if (m_if.Hist_count !== exps[k]) begin
                n_fail++;
                $display("FAIL hist_sel%0d: got %0d expected %0d", sels[k], m_if.Hist_count, exps[k]);
            end
        end
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        n_checks = 0;
        n_fail   = 0;
        Reset    = 1'b0;
        test_reset();
        test_all_symbols();
        test_frame_end();
        test_bit_valid_toggle();
        test_reset_mid_codeword();
        test_error();
`ifdef HUFF_DECODE_HIST_EN
        test_hist();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
